uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo.sv | 148 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding an 8N1 UART transmitter. Frames are sent back-to-back while the
// FIFO holds data, and txd/busy are registered one cycle behind the FSM state.
module uart_tx_fifo #(
    parameter int unsigned CLK_PER_HALF_BIT = 30,
    parameter int unsigned DEPTH_LOG2       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  busy,
    output logic                  txd
);

    localparam int unsigned Depth     = 2 ** DEPTH_LOG2;
    localparam int unsigned BitCycles = 2 * CLK_PER_HALF_BIT;
    localparam int unsigned CntW      = $clog2(BitCycles + 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e                state_q;
    logic [CntW-1:0]       period_q;
    logic [2:0]            bit_q;
    logic [7:0]            shift_q;
    logic                  txd_q;
    logic                  busy_q;
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  overflow_q;
    logic [7:0]            mem [Depth];

    logic       bit_end;
    logic       have_data;
    logic       full_w;
    logic       wr_accept;
    logic       pop;
    logic [7:0] head;

    // full comes from the registered count only, so a same-cycle pop never frees a slot
    always_comb begin
        bit_end   = (period_q == CntW'(BitCycles - 1));
        have_data = (count_q != '0);
        full_w    = (count_q == (DEPTH_LOG2 + 1)'(Depth));
        wr_accept = wr_en && !full_w && !rst;
        pop       = have_data && ((state_q == StIdle) || ((state_q == StStop) && bit_end));
        head      = mem[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_accept) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)       rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({wr_accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (wr_en && full_w) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            period_q <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            busy_q <= (state_q != StIdle);
            unique case (state_q)
                StIdle: begin
                    txd_q    <= 1'b1;
                    period_q <= '0;
                    if (pop) begin
                        shift_q <= head;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    txd_q <= 1'b0;
                    if (bit_end) begin
                        period_q <= '0;
                        bit_q    <= '0;
                        state_q  <= StData;
                    end else begin
                        period_q <= period_q + 1'b1;
                    end
                end
                StData: begin
                    txd_q <= shift_q[0];
                    if (bit_end) begin
                        period_q <= '0;
                        shift_q  <= {1'b0, shift_q[7:1]};
                        if (bit_q == 3'd7) begin
                            state_q <= StStop;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                        end
                    end else begin
                        period_q <= period_q + 1'b1;
                    end
                end
                StStop: begin
                    txd_q <= 1'b1;
                    if (bit_end) begin
                        period_q <= '0;
                        // Next byte starts with no idle gap
                        if (pop) begin
                            shift_q <= head;
                            state_q <= StStart;
                        end else begin
                            state_q <= StIdle;
                        end
                    end else begin
                        period_q <= period_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign full     = full_w;
    assign empty    = !have_data;
    assign count    = count_q;
    assign overflow = overflow_q;
    assign busy     = busy_q;
    assign txd      = txd_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a fast instance (half bit = 2) and a loopback
// instance at the default rate, both decoded by a simple mid-bit sampling receiver.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] wr_data, wr_data30;
    logic       wr_en, wr_en30;
    logic       full, empty, overflow, busy, txd;
    logic [4:0] count;
    logic       full30, empty30, overflow30, busy30, txd30;
    logic [4:0] count30;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_fifo #(.CLK_PER_HALF_BIT(2), .DEPTH_LOG2(4)) dut (
        .clk(clk), .rst(rst), .wr_data(wr_data), .wr_en(wr_en), .full(full),
        .empty(empty), .count(count), .overflow(overflow), .busy(busy), .txd(txd)
    );

    uart_tx_fifo #(.CLK_PER_HALF_BIT(30), .DEPTH_LOG2(4)) dut30 (
        .clk(clk), .rst(rst), .wr_data(wr_data30), .wr_en(wr_en30), .full(full30),
        .empty(empty30), .count(count30), .overflow(overflow30), .busy(busy30), .txd(txd30)
    );

    // Waits (bounded) for a start bit, then samples each bit at its middle.
    task automatic rx_frame(input bit slow, output logic [7:0] data, output bit ferr,
                            output int start_cyc, output bit ok);
        int half;
        half = slow ? 30 : 2;
        ok = 1'b0; ferr = 1'b0; data = '0; start_cyc = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ((slow ? txd30 : txd) === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) return;
        start_cyc = cyc;
        repeat (half) @(negedge clk);
        if ((slow ? txd30 : txd) !== 1'b0) ferr = 1'b1;
        for (int b = 0; b < 8; b++) begin
            repeat (2 * half) @(negedge clk);
            data[b] = slow ? txd30 : txd;
        end
        repeat (2 * half) @(negedge clk);
        if ((slow ? txd30 : txd) !== 1'b1) ferr = 1'b1;
    endtask

    task automatic do_reset;
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'hFF; wr_en30 = 1'b1; wr_data30 = 8'hFF;
        repeat (2) @(negedge clk);
        rst = 1'b0; wr_en = 1'b0; wr_en30 = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        tests_run++; if (txd !== 1'b1) begin tests_failed++; $display("FAIL reset_txd got %b want 1", txd); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++; if (count !== 5'd0) begin tests_failed++; $display("FAIL reset_count got %0d want 0", count); end
        tests_run++; if (empty !== 1'b1) begin tests_failed++; $display("FAIL reset_empty got %b want 1", empty); end
        tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL reset_full got %b want 0", full); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow got %b want 0", overflow); end
        tests_run++; if (txd30 !== 1'b1) begin tests_failed++; $display("FAIL reset_txd30 got %b want 1", txd30); end
        repeat (4) @(negedge clk);
        tests_run++; if (busy !== 1'b0 || txd !== 1'b1) begin tests_failed++; $display("FAIL reset_idle busy=%b txd=%b want 0/1", busy, txd); end
    endtask

    task automatic test_single;
        logic [7:0] d;
        logic       exp;
        int         busy_cycles;
        do_reset();
        d = 8'hAA;
        wr_data = d; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        tests_run++; if (count !== 5'd1) begin tests_failed++; $display("FAIL single_count_k got %0d want 1", count); end
        @(negedge clk);
        tests_run++; if (count !== 5'd0) begin tests_failed++; $display("FAIL single_pop got %0d want 0", count); end
        tests_run++; if (txd !== 1'b1) begin tests_failed++; $display("FAIL single_latency got %b want 1", txd); end
        busy_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            exp = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : d[i-1];
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (busy === 1'b1) busy_cycles++;
                tests_run++;
                if (txd !== exp) begin
                    tests_failed++;
                    $display("FAIL single_bit%0d_c%0d got %b want %b", i, c, txd, exp);
                end
            end
        end
        repeat (4) begin
            @(negedge clk);
            if (busy === 1'b1) busy_cycles++;
        end
        tests_run++; if (busy_cycles != 40) begin tests_failed++; $display("FAIL single_busy_len got %0d want 40", busy_cycles); end
        tests_run++; if (busy !== 1'b0 || empty !== 1'b1) begin tests_failed++; $display("FAIL single_end busy=%b empty=%b want 0/1", busy, empty); end
    endtask

    task automatic test_overflow;
        logic [7:0] d;
        bit         fe, ok;
        int         sc, prev;
        do_reset();
        prev = 0;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    wr_data = 8'(i); wr_en = 1'b1;
                    @(negedge clk);
                    if (i == 16) begin
                        tests_run++; if (full !== 1'b1) begin tests_failed++; $display("FAIL ovf_full got %b want 1", full); end
                        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL ovf_early got %b want 0", overflow); end
                    end
                end
                wr_en = 1'b0;
                tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_sticky got %b want 1", overflow); end
                tests_run++; if (count !== 5'd16) begin tests_failed++; $display("FAIL ovf_count got %0d want 16", count); end
            end
            begin
                for (int f = 0; f < 17; f++) begin
                    rx_frame(1'b0, d, fe, sc, ok);
                    tests_run++;
                    if (!ok || fe || d !== 8'(f)) begin
                        tests_failed++;
                        $display("FAIL ovf_frame%0d got %h ok=%b ferr=%b want %h", f, d, ok, fe, 8'(f));
                    end
                    if (f > 0) begin
                        tests_run++;
                        if (sc - prev != 40) begin tests_failed++; $display("FAIL ovf_gap%0d got %0d want 40", f, sc - prev); end
                    end
                    prev = sc;
                end
            end
        join
        repeat (20) @(negedge clk);
        tests_run++; if (busy !== 1'b0 || empty !== 1'b1) begin tests_failed++; $display("FAIL ovf_drained busy=%b empty=%b want 0/1", busy, empty); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL ovf_hold got %b want 1", overflow); end
    endtask

    task automatic test_full_boundary;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            wr_data = 8'(8'h40 + i); wr_en = 1'b1;
            @(negedge clk);
        end
        wr_en = 1'b0;
        repeat (24) @(negedge clk);
        tests_run++; if (count !== 5'd16 || full !== 1'b1) begin tests_failed++; $display("FAIL bnd_pre count=%0d full=%b want 16/1", count, full); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL bnd_pre_ovf got %b want 0", overflow); end
        wr_data = 8'hEE; wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        tests_run++; if (count !== 5'd15) begin tests_failed++; $display("FAIL bnd_count got %0d want 15", count); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("FAIL bnd_overflow got %b want 1", overflow); end
        tests_run++; if (full !== 1'b0) begin tests_failed++; $display("FAIL bnd_full got %b want 0", full); end
    endtask

    task automatic test_reset_mid;
        logic [7:0] d;
        logic [7:0] seq [5];
        bit         fe, ok, stayed_high;
        int         sc;
        seq = '{8'h5A, 8'h11, 8'h22, 8'h33, 8'h44};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            wr_data = seq[i]; wr_en = 1'b1;
            @(negedge clk);
        end
        wr_en = 1'b0;
        tests_run++; if (count !== 5'd4) begin tests_failed++; $display("FAIL mid_queued got %0d want 4", count); end
        repeat (13) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests_run++; if (txd !== 1'b1) begin tests_failed++; $display("FAIL mid_txd got %b want 1", txd); end
        tests_run++; if (count !== 5'd0) begin tests_failed++; $display("FAIL mid_count got %0d want 0", count); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy got %b want 0", busy); end
        stayed_high = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0) stayed_high = 1'b0;
        end
        tests_run++; if (!stayed_high) begin tests_failed++; $display("FAIL mid_abort got 0 want 1"); end
        fork
            begin
                wr_data = 8'h3C; wr_en = 1'b1;
                @(negedge clk);
                wr_en = 1'b0;
            end
            rx_frame(1'b0, d, fe, sc, ok);
        join
        tests_run++; if (!ok || fe || d !== 8'h3C) begin tests_failed++; $display("FAIL mid_after got %h ok=%b ferr=%b want 3c", d, ok, fe); end
    endtask

    task automatic test_loopback;
        logic [7:0] d;
        logic [7:0] seq [4];
        bit         fe, ok;
        int         sc;
        seq = '{8'h00, 8'hFF, 8'h55, 8'h0A};
        do_reset();
        fork
            begin
                for (int i = 0; i < 4; i++) begin
                    wr_data30 = seq[i]; wr_en30 = 1'b1;
                    @(negedge clk);
                end
                wr_en30 = 1'b0;
            end
            begin
                for (int f = 0; f < 4; f++) begin
                    rx_frame(1'b1, d, fe, sc, ok);
                    tests_run++;
                    if (!ok || fe || d !== seq[f]) begin
                        tests_failed++;
                        $display("FAIL loop_frame%0d got %h ok=%b ferr=%b want %h", f, d, ok, fe, seq[f]);
                    end
                end
            end
        join
        repeat (40) @(negedge clk);
        tests_run++;
        if (busy30 !== 1'b0 || empty30 !== 1'b1 || count30 !== 5'd0 || full30 !== 1'b0 || overflow30 !== 1'b0) begin
            tests_failed++;
            $display("FAIL loop_end busy=%b empty=%b count=%0d full=%b ovf=%b want 0/1/0/0/0",
                     busy30, empty30, count30, full30, overflow30);
        end
    endtask

    task automatic test_wrap;
        logic [7:0] d;
        bit         fe, ok;
        int         sc;
        do_reset();
        for (int b = 0; b < 4; b++) begin
            fork
                begin
                    for (int j = 0; j < 10; j++) begin
                        wr_data = 8'((b * 10 + j) * 37 + 5); wr_en = 1'b1;
                        @(negedge clk);
                    end
                    wr_en = 1'b0;
                end
                begin
                    for (int j = 0; j < 10; j++) begin
                        rx_frame(1'b0, d, fe, sc, ok);
                        tests_run++;
                        if (!ok || fe || d !== 8'((b * 10 + j) * 37 + 5)) begin
                            tests_failed++;
                            $display("FAIL wrap_b%0d_%0d got %h ok=%b ferr=%b want %h",
                                     b, j, d, ok, fe, 8'((b * 10 + j) * 37 + 5));
                        end
                    end
                end
            join
            repeat (10) @(negedge clk);
            tests_run++; if (empty !== 1'b1 || busy !== 1'b0) begin tests_failed++; $display("FAIL wrap_idle%0d empty=%b busy=%b want 1/0", b, empty, busy); end
        end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("FAIL wrap_overflow got %b want 0", overflow); end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; wr_en30 = 1'b0; wr_data30 = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_overflow();
        test_full_boundary();
        test_reset_mid();
        test_loopback();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
